// File: rtl/divider_pkg.sv
// Shared types for the divider request sequencer.
// Holds the sequencer state enum and level-width helper.
package divider_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_RESP
  } seq_state_t;

  function automatic int lvl_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/divider_req_fifo.sv
// Request buffer for the divider sequencer.
// Power-of-two depth, pointers wrap naturally.
module divider_req_fifo
  import divider_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        ce,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [lvl_bits(DEPTH)-1:0]  level,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_bits(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (ce) begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!srst && ce && do_push)
      mem[wptr] <= wdata;
  end

endmodule

// File: rtl/divider_req_sequencer.sv
// Buffers operand requests and sequences them through a divider.
// Option: DIVIDER_REQ_SEQUENCER_ZERO_BYPASS_EN answers den=0 locally.
module divider_req_sequencer
  import divider_pkg::*;
#(
  parameter int DIV_NUM_BITS = 8,
  parameter int DIV_DEN_BITS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    CLK,
  input  logic                    SRST,
  input  logic                    CE,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [DIV_NUM_BITS-1:0] REQ_NUM,
  input  logic [DIV_DEN_BITS-1:0] REQ_DEN,
  output logic                    DIV_START,
  output logic [DIV_NUM_BITS-1:0] DIV_NUM,
  output logic [DIV_DEN_BITS-1:0] DIV_DEN,
  input  logic [DIV_NUM_BITS-1:0] DIV_QUOT,
  input  logic [DIV_DEN_BITS-1:0] DIV_REM,
  input  logic                    DIV_ERROR,
  input  logic                    DIV_DONE,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DIV_NUM_BITS-1:0] RSP_QUOT,
  output logic [DIV_DEN_BITS-1:0] RSP_REM,
  output logic                    RSP_ERROR,
  output logic [lvl_bits(FIFO_DEPTH)-1:0] FIFO_LEVEL
);

  localparam int EW = DIV_NUM_BITS + DIV_DEN_BITS;

  seq_state_t state;
  seq_state_t state_nx;

  logic [EW-1:0]           head;
  logic [DIV_NUM_BITS-1:0] head_num;
  logic [DIV_DEN_BITS-1:0] head_den;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    byp_hit;
  logic                    load_rsp;
  logic                    load_byp;

  logic [DIV_NUM_BITS-1:0] op_num;
  logic [DIV_DEN_BITS-1:0] op_den;
  logic [DIV_NUM_BITS-1:0] rsp_quot;
  logic [DIV_DEN_BITS-1:0] rsp_rem;
  logic                    rsp_err;

  assign REQ_READY = CE & ~SRST & ~full;
  assign push      = REQ_VALID & REQ_READY;
  assign head_num  = head[EW-1 -: DIV_NUM_BITS];
  assign head_den  = head[DIV_DEN_BITS-1:0];

`ifdef DIVIDER_REQ_SEQUENCER_ZERO_BYPASS_EN
  assign byp_hit = (head_den == '0);
`else
  assign byp_hit = 1'b0;
`endif

  divider_req_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .srst  (SRST),
    .ce    (CE),
    .push  (push),
    .pop   (pop),
    .wdata ({REQ_NUM, REQ_DEN}),
    .rdata (head),
    .level (FIFO_LEVEL),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load_rsp = 1'b0;
    load_byp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (byp_hit) begin
            load_byp = 1'b1;
            state_nx = S_RESP;
          end else begin
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_nx = S_ARM;
      // DONE may still be high from the previous job here
      S_ARM:   state_nx = S_WAIT;
      S_WAIT: begin
        if (DIV_DONE) begin
          load_rsp = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if (RSP_READY) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      state    <= S_IDLE;
      op_num   <= '0;
      op_den   <= '0;
      rsp_quot <= '0;
      rsp_rem  <= '0;
      rsp_err  <= 1'b0;
    end else if (CE) begin
      state <= state_nx;
      if (pop) begin
        op_num <= head_num;
        op_den <= head_den;
      end
      if (load_rsp) begin
        rsp_quot <= DIV_QUOT;
        rsp_rem  <= DIV_REM;
        rsp_err  <= DIV_ERROR;
      end
      if (load_byp) begin
        rsp_quot <= '1;
        rsp_rem  <= DIV_DEN_BITS'(head_num);
        rsp_err  <= 1'b1;
      end
    end
  end

  assign DIV_START = CE & ~SRST & (state == S_ISSUE);
  assign RSP_VALID = CE & ~SRST & (state == S_RESP);
  assign DIV_NUM   = op_num;
  assign DIV_DEN   = op_den;
  assign RSP_QUOT  = rsp_quot;
  assign RSP_REM   = rsp_rem;
  assign RSP_ERROR = rsp_err;

endmodule

// File: tb/tb_divider_req_sequencer.sv
// Directed bench for divider_req_sequencer with a behavioural divider.
// Honours DIVIDER_REQ_SEQUENCER_ZERO_BYPASS_EN like the RTL.
module tb_divider_req_sequencer;

  logic       tb_clk = 1'b0;
  logic       tb_srst = 1'b1;
  logic       tb_ce = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_num = '0;
  logic [7:0] req_den = '0;
  logic       div_start;
  logic [7:0] div_num;
  logic [7:0] div_den;
  logic [7:0] div_quot;
  logic [7:0] div_rem;
  logic       div_error;
  logic       div_done;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_quot;
  logic [7:0] rsp_rem;
  logic       rsp_error;
  logic [2:0] fifo_level;

  int n_chk = 0;
  int n_pass = 0;
  int start_cnt = 0;
  bit stall = 1'b0;
  bit sweep_done = 1'b0;

  always #5 tb_clk = ~tb_clk;

  divider_req_sequencer dut (
    .CLK        (tb_clk),
    .SRST       (tb_srst),
    .CE         (tb_ce),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_NUM    (req_num),
    .REQ_DEN    (req_den),
    .DIV_START  (div_start),
    .DIV_NUM    (div_num),
    .DIV_DEN    (div_den),
    .DIV_QUOT   (div_quot),
    .DIV_REM    (div_rem),
    .DIV_ERROR  (div_error),
    .DIV_DONE   (div_done),
    .RSP_VALID  (rsp_valid),
    .RSP_READY  (rsp_ready),
    .RSP_QUOT   (rsp_quot),
    .RSP_REM    (rsp_rem),
    .RSP_ERROR  (rsp_error),
    .FIFO_LEVEL (fifo_level)
  );

  // divider model: DONE lingers one cycle past START
  logic [7:0] opn, opd;
  logic [1:0] cnt;
  logic       busy, stale;

  always @(posedge tb_clk) begin
    if (tb_srst) begin
      busy <= 1'b0; stale <= 1'b0; cnt <= '0;
      div_done <= 1'b0; div_error <= 1'b0;
      div_quot <= '0; div_rem <= '0;
      opn <= '0; opd <= '0;
    end else if (tb_ce) begin
      if (div_start) begin
        busy <= 1'b1; stale <= 1'b1; cnt <= 2'd3;
        opn <= div_num; opd <= div_den;
      end else begin
        if (stale) begin
          div_done <= 1'b0; stale <= 1'b0;
        end
        if (busy && !stall) begin
          if (cnt == 0) begin
            busy <= 1'b0;
            div_done <= 1'b1;
            div_error <= (opd == 0);
            div_quot <= (opd == 0) ? 8'hFF : opn / opd;
            div_rem <= (opd == 0) ? opn : opn % opd;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end
  end

  always @(posedge tb_clk)
    if (!tb_srst && tb_ce && div_start) start_cnt <= start_cnt + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] n, input logic [7:0] d);
    bit ok = 1'b0;
    req_num = n; req_den = d; req_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (req_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check("push_timeout", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check("rsp_timeout", 0, 1);
  endtask

  logic [15:0] sb[$];
  logic [15:0] got[$];
  logic [15:0] bexp[6];
  logic [7:0]  bn[5];
  logic [7:0]  bd[5];

  initial begin
    int s0, acc, bad, nrsp, cyc;
    bit pend, xr, v, e;
    logic [7:0] q0, r0, q, r;
    logic [15:0] ent;

    // reset state
    tb_srst = 1'b1;
    tick(); tick();
    check("rst_level", fifo_level, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_div_start", div_start, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_div_num", div_num, 0);
    check("rst_div_den", div_den, 0);
    check("rst_rsp", {rsp_error, rsp_quot, rsp_rem}, 0);
    tb_srst = 1'b0;
    tick();

    // single 200/7 and its latency
    req_num = 8'd200; req_den = 8'd7; req_valid = 1'b1;
    check("idle_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("lat_k1_start", div_start, 0);
    tick();
    check("lat_k2_start", div_start, 1);
    check("issue_num", div_num, 200);
    check("issue_den", div_den, 7);
    tick();
    check("start_one_cycle", div_start, 0);
    for (int t = 0; t < 50 && !div_done; t++) tick();
    check("done_seen", div_done, 1);
    check("pre_rsp_valid", rsp_valid, 0);
    tick();
    check("lat_rsp_valid", rsp_valid, 1);
    check("q200_7", rsp_quot, 28);
    check("r200_7", rsp_rem, 4);
    check("e200_7", rsp_error, 0);
    tick();
    check("rsp_drop", rsp_valid, 0);

    // back-pressure hold and CE=0 freeze
    rsp_ready = 1'b0;
    s0 = start_cnt;
    push(8'd100, 8'd9);
    wait_rsp();
    q0 = rsp_quot; r0 = rsp_rem;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (!rsp_valid || rsp_quot !== q0 || rsp_rem !== r0) bad++;
    end
    check("hold_stable", bad, 0);
    check("hold_q", q0, 11);
    check("hold_r", r0, 1);
    check("hold_starts", start_cnt - s0, 1);
    tb_ce = 1'b0;
    #1;
    check("ce0_rsp_valid", rsp_valid, 0);
    check("ce0_req_ready", req_ready, 0);
    check("ce0_div_start", div_start, 0);
    tick(); tick();
    check("ce0_quot", rsp_quot, 11);
    tb_ce = 1'b1;
    #1;
    check("ce1_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    check("hold_release", rsp_valid, 0);

    // burst of five behind a stalled divider
    stall = 1'b1;
    push(8'd50, 8'd5);
    repeat (4) tick();
    bn = '{8'd60, 8'd90, 8'd255, 8'd17, 8'd33};
    bd = '{8'd7, 8'd10, 8'd16, 8'd3, 8'd4};
    bexp = '{16'h0A00, 16'h0804, 16'h0900,
             16'h0F0F, 16'h0502, 16'h0801};
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      req_num = bn[i]; req_den = bd[i]; req_valid = 1'b1;
      if (!req_ready) break;
      tick();
      acc++;
    end
    check("burst_accepts", acc, 4);
    check("burst_level", fifo_level, 4);
    check("burst_ready", req_ready, 0);
    pend = (acc < 5);
    if (!pend) req_valid = 1'b0;
    stall = 1'b0;
    got.delete();
    for (int c = 0; c < 300 && got.size() < 6; c++) begin
      xr = pend && req_ready;
      if (rsp_valid) got.push_back({rsp_quot, rsp_rem});
      tick();
      if (xr) begin pend = 1'b0; req_valid = 1'b0; end
    end
    req_valid = 1'b0;
    check("burst_count", got.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < got.size()) check($sformatf("burst_rsp%0d", k), got[k], bexp[k]);

    // zero denominator
    rsp_ready = 1'b0;
    s0 = start_cnt;
    push(8'd13, 8'd0);
    wait_rsp();
    check("z_err", rsp_error, 1);
`ifdef DIVIDER_REQ_SEQUENCER_ZERO_BYPASS_EN
    check("z_quot", rsp_quot, 8'hFF);
    check("z_rem", rsp_rem, 13);
    check("z_starts", start_cnt - s0, 0);
`else
    check("z_starts", start_cnt - s0, 1);
`endif
    rsp_ready = 1'b1;
    tick();
    check("z_release", rsp_valid, 0);

    // reset while waiting with three queued
    stall = 1'b1;
    push(8'd40, 8'd3);
    push(8'd1, 8'd1);
    push(8'd2, 8'd1);
    push(8'd3, 8'd1);
    tick();
    check("mid_level", fifo_level, 3);
    tb_srst = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 0);
    tick();
    tb_srst = 1'b0;
    stall = 1'b0;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_num", div_num, 0);
    s0 = start_cnt;
    bad = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (rsp_valid) bad++;
    end
    check("mid_no_rsp", bad, 0);
    check("mid_no_start", start_cnt - s0, 0);
    rsp_ready = 1'b0;
    push(8'd77, 8'd8);
    wait_rsp();
    check("post_rst_q", rsp_quot, 9);
    check("post_rst_r", rsp_rem, 5);
    rsp_ready = 1'b1;
    tick();

    // strided operand sweep with random CE
    sb.delete();
    nrsp = 0;
    fork
      begin
        bit xf;
        @(posedge tb_clk); #1;
        for (int n = 0; n < 256; n += 17)
          for (int d = 0; d < 256; d += 15) begin
            req_num = n[7:0]; req_den = d[7:0]; req_valid = 1'b1;
            xf = 1'b0;
            for (int t = 0; t < 2000 && !xf; t++) begin
              #7; xf = req_ready;
              @(posedge tb_clk); #1;
            end
            if (xf) sb.push_back({n[7:0], d[7:0]});
            else check("sw_push_timeout", 0, 1);
          end
        req_valid = 1'b0;
      end
      begin
        @(posedge tb_clk); #1;
        cyc = 0;
        while (nrsp < 288 && cyc < 30000) begin
          #7;
          v = rsp_valid; q = rsp_quot; r = rsp_rem; e = rsp_error;
          @(posedge tb_clk); #1;
          cyc++;
          if (v) begin
            nrsp++;
            if (sb.size() == 0) begin
              check("sw_extra", 1, 0);
            end else begin
              ent = sb.pop_front();
              if (ent[7:0] == 0) begin
                check("sw_err", e, 1);
`ifdef DIVIDER_REQ_SEQUENCER_ZERO_BYPASS_EN
                check("sw_byp", {q, r}, {8'hFF, ent[15:8]});
`endif
              end else begin
                check($sformatf("sw_%0d_%0d", ent[15:8], ent[7:0]),
                      {e, q, r},
                      {1'b0, ent[15:8] / ent[7:0], ent[15:8] % ent[7:0]});
              end
            end
          end
        end
        if (nrsp < 288) check("sw_timeout", nrsp, 288);
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(negedge tb_clk);
          tb_ce = ($urandom_range(0, 3) != 0);
        end
        tb_ce = 1'b1;
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
